// File: rtl/gpr_writeback_arbiter.sv
// gpr_writeback_arbiter: round-robin ALU/MEM/MDU arbiter feeding an in-order FIFO that drives the GPR write port (forwarding: WB_FORWARD_EN).
// Latency: accept at edge N -> rf_write_enable in cycle N+1; backpressure: ready drops when full without a pop, wb_stall holds the drain.
module gpr_writeback_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          alu_valid,
   input  logic [ADDR_W-1:0]             alu_addr,
   input  logic [DATA_W-1:0]             alu_data,
   output logic                          alu_ready,
   input  logic                          mem_valid,
   input  logic [ADDR_W-1:0]             mem_addr,
   input  logic [DATA_W-1:0]             mem_data,
   output logic                          mem_ready,
   input  logic                          mdu_valid,
   input  logic [ADDR_W-1:0]             mdu_addr,
   input  logic [DATA_W-1:0]             mdu_data,
   output logic                          mdu_ready,
   input  logic                          wb_stall,
   output logic                          rf_write_enable,
   output logic [ADDR_W-1:0]             rf_write,
   output logic [DATA_W-1:0]             rf_write_data,
   output logic [$clog2(FIFO_DEPTH):0]   pending_count,
   input  logic [ADDR_W-1:0]             fwd_addr,
   output logic                          fwd_hit,
   output logic [DATA_W-1:0]             fwd_data
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   wb_entry_t        fifo_q [FIFO_DEPTH];
   wb_entry_t        win_entry;
   wb_entry_t        head;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [1:0]       rr_q, rr_next;
   logic [2:0]       req_vld, grant, ready;
   logic             empty, full, pop, push, transfer;

   assign req_vld = {mdu_valid, mem_valid, alu_valid};

   // rr_q: 0 = ALU, 1 = MEM, 2 = MDU; first valid source in rotation wins
   always_comb begin
      grant = '0;
      case (rr_q)
         2'd1: begin
            if      (req_vld[1]) grant = 3'b010;
            else if (req_vld[2]) grant = 3'b100;
            else if (req_vld[0]) grant = 3'b001;
         end
         2'd2: begin
            if      (req_vld[2]) grant = 3'b100;
            else if (req_vld[0]) grant = 3'b001;
            else if (req_vld[1]) grant = 3'b010;
         end
         default: begin
            if      (req_vld[0]) grant = 3'b001;
            else if (req_vld[1]) grant = 3'b010;
            else if (req_vld[2]) grant = 3'b100;
         end
      endcase
   end

   always_comb begin
      win_entry = '{addr: alu_addr, data: alu_data};
      rr_next   = 2'd1;
      if (grant[1]) begin
         win_entry = '{addr: mem_addr, data: mem_data};
         rr_next   = 2'd2;
      end else if (grant[2]) begin
         win_entry = '{addr: mdu_addr, data: mdu_data};
         rr_next   = 2'd0;
      end
   end

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop      = !empty && !wb_stall;
   assign ready    = reset ? 3'b000 : (grant & {3{!full || pop}});
   assign transfer = |ready;
   // r0 writes complete the handshake but are never queued
   assign push     = transfer && (win_entry.addr != '0);

   assign alu_ready = ready[0];
   assign mem_ready = ready[1];
   assign mdu_ready = ready[2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rr_q     <= 2'd0;
      end else begin
         if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
         if (transfer) rr_q <= rr_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= win_entry;
   end

   assign head            = fifo_q[rd_ptr_q];
   assign rf_write_enable = pop;
   assign rf_write        = empty ? '0 : head.addr;
   assign rf_write_data   = empty ? '0 : head.data;
   assign pending_count   = count_q;

`ifdef WB_FORWARD_EN
   // Walk oldest to youngest so the last match left standing is the youngest
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx      = '0;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         idx = rd_ptr_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (fwd_addr != '0) && (fifo_q[idx].addr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = fifo_q[idx].data;
         end
      end
   end
`else
   logic unused_fwd_addr;
   assign unused_fwd_addr = ^fwd_addr;
   assign fwd_hit         = 1'b0;
   assign fwd_data        = '0;
`endif

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// Randomized bench: a queue-based reference model predicts every output each cycle, including mid-run resets.
module tb_gpr_writeback_arbiter;

   localparam int DEPTH = 4;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   logic        clk, reset;
   logic        alu_valid, mem_valid, mdu_valid;
   logic [4:0]  alu_addr, mem_addr, mdu_addr;
   logic [31:0] alu_data, mem_data, mdu_data;
   logic        alu_ready, mem_ready, mdu_ready;
   logic        wb_stall;
   logic        rf_write_enable;
   logic [4:0]  rf_write;
   logic [31:0] rf_write_data;
   logic [2:0]  pending_count;
   logic [4:0]  fwd_addr;
   logic        fwd_hit;
   logic [31:0] fwd_data;

   int total = 0;
   int bad   = 0;

   ent_t        q[$];
   int          rr;
   logic        req_v [3];
   logic [4:0]  req_a [3];
   logic [31:0] req_d [3];
   bit          accepted [3];

   gpr_writeback_arbiter dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
      .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
      .wb_stall(wb_stall),
      .rf_write_enable(rf_write_enable), .rf_write(rf_write), .rf_write_data(rf_write_data),
      .pending_count(pending_count),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic drive();
      alu_valid = req_v[0]; alu_addr = req_a[0]; alu_data = req_d[0];
      mem_valid = req_v[1]; mem_addr = req_a[1]; mem_data = req_d[1];
      mdu_valid = req_v[2]; mdu_addr = req_a[2]; mdu_data = req_d[2];
   endtask

   task automatic check_all_zero(input string pfx);
      check_eq({pfx, "_alu_ready"}, alu_ready, 0);
      check_eq({pfx, "_mem_ready"}, mem_ready, 0);
      check_eq({pfx, "_mdu_ready"}, mdu_ready, 0);
      check_eq({pfx, "_rf_we"}, rf_write_enable, 0);
      check_eq({pfx, "_rf_write"}, rf_write, 0);
      check_eq({pfx, "_rf_data"}, rf_write_data, 0);
      check_eq({pfx, "_pending"}, pending_count, 0);
      check_eq({pfx, "_fwd_hit"}, fwd_hit, 0);
      check_eq({pfx, "_fwd_data"}, fwd_data, 0);
   endtask

   task automatic clear_requests();
      for (int s = 0; s < 3; s++) begin
         req_v[s] = 1'b0;
         accepted[s] = 1'b0;
      end
      drive();
   endtask

   // Predict this cycle's outputs from the model, compare, then advance the model across the coming edge
   task automatic check_and_advance();
      int   win;
      bit   pop_e, cap;
      bit   eh;
      logic [31:0] ed;
      win   = -1;
      for (int k = 0; k < 3; k++) begin
         int s;
         s = (rr + k) % 3;
         if (win < 0 && req_v[s]) win = s;
      end
      pop_e = (q.size() > 0) && !wb_stall;
      cap   = (q.size() < DEPTH) || pop_e;
      eh    = 1'b0;
      ed    = '0;
`ifdef WB_FORWARD_EN
      if (fwd_addr != 0)
         for (int k = 0; k < q.size(); k++)
            if (q[k].a == fwd_addr) begin
               eh = 1'b1;
               ed = q[k].d;
            end
`endif
      check_eq("alu_ready", alu_ready, (win == 0) && cap);
      check_eq("mem_ready", mem_ready, (win == 1) && cap);
      check_eq("mdu_ready", mdu_ready, (win == 2) && cap);
      check_eq("rf_we", rf_write_enable, pop_e);
      check_eq("rf_write", rf_write, (q.size() > 0) ? q[0].a : 5'd0);
      check_eq("rf_data", rf_write_data, (q.size() > 0) ? q[0].d : 32'd0);
      check_eq("pending", pending_count, q.size());
      check_eq("fwd_hit", fwd_hit, eh);
      check_eq("fwd_data", fwd_data, ed);

      for (int s = 0; s < 3; s++) accepted[s] = 1'b0;
      if (pop_e) void'(q.pop_front());
      if (win >= 0 && cap) begin
         ent_t e;
         accepted[win] = 1'b1;
         e.a = req_a[win];
         e.d = req_d[win];
         if (e.a != 0) q.push_back(e);
         rr = (win + 1) % 3;
      end
   endtask

   initial begin
      int pv, ps;
      rr = 0;
      reset = 1'b1;
      wb_stall = 1'b0;
      fwd_addr = 5'd3;
      for (int s = 0; s < 3; s++) begin
         req_v[s] = 1'b1;
         req_a[s] = 5'(s + 1);
         req_d[s] = 32'hA000_0000 + s;
         accepted[s] = 1'b0;
      end
      drive();
      #2;
      check_all_zero("rst");
      clear_requests();
      #10 reset = 1'b0;

      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(posedge clk); #1;
         if (cyc < 300)      begin pv = 40;  ps = 20; end
         else if (cyc < 600) begin pv = 100; ps = 0;  end
         else if (cyc < 900) begin pv = 60;  ps = 85; end
         else                begin pv = 50;  ps = 40; end
         for (int s = 0; s < 3; s++) begin
            // a source holds its request until it is accepted
            if (!(req_v[s] && !accepted[s])) begin
               req_v[s] = ($urandom_range(0, 99) < pv);
               req_a[s] = 5'($urandom_range(0, 7));
               req_d[s] = $urandom;
            end
         end
         drive();
         wb_stall = ($urandom_range(0, 99) < ps);
         fwd_addr = 5'($urandom_range(0, 7));

         if (cyc == 450 || cyc == 760 || cyc == 1210) begin
            #2 reset = 1'b1;
            #1;
            check_all_zero("rst_mid");
            q.delete();
            rr = 0;
            clear_requests();
            @(negedge clk);
            @(posedge clk);
            #3 reset = 1'b0;
         end else begin
            @(negedge clk);
            check_and_advance();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
